// File: rtl/qs_out_chk_if.sv
// Bundles the sorter output stream and the packet status channel of qs_out_chk.
interface qs_out_chk_if #(
  parameter int unsigned W     = 32,
  parameter int unsigned LEN_W = 5
);
  logic               in_vld;
  logic               in_sop;
  logic               in_eop;
  logic               in_err;
  logic [W-1:0]       in_dat;
  logic               stat_vld_r;
  logic               stat_rdy;
  logic [LEN_W-1:0]   stat_len_r;
  logic [W+LEN_W-1:0] stat_sum_r;
  logic [3:0]         stat_code_r;
  logic               stat_ok_r;
  logic [7:0]         cnt_orphan_r;
  logic [7:0]         cnt_drop_r;

  modport master (
    output in_vld, in_sop, in_eop, in_err, in_dat, stat_rdy,
    input  stat_vld_r, stat_len_r, stat_sum_r, stat_code_r, stat_ok_r,
           cnt_orphan_r, cnt_drop_r
  );

  modport slave (
    input  in_vld, in_sop, in_eop, in_err, in_dat, stat_rdy,
    output stat_vld_r, stat_len_r, stat_sum_r, stat_code_r, stat_ok_r,
           cnt_orphan_r, cnt_drop_r
  );
endinterface

// File: rtl/qs_out_chk.sv
// Checks packets leaving the sorter: framing, ascending order, length and error,
// and reports one status per completed packet plus orphan/drop counters.
module qs_out_chk #(
  parameter int unsigned W     = 32,
  parameter int unsigned N     = 16,
  parameter int unsigned LEN_W = $clog2(N) + 1
) (
  input logic         clk,
  input logic         rst,
  qs_out_chk_if.slave bus
);
  localparam int unsigned SW = W + LEN_W;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           r_state;
  logic [W-1:0]     r_prev;
  logic [LEN_W-1:0] r_len;
  logic [SW-1:0]    r_sum;
  logic [3:0]       r_code;

  logic             r_stat_vld;
  logic [LEN_W-1:0] r_stat_len;
  logic [SW-1:0]    r_stat_sum;
  logic [3:0]       r_stat_code;
  logic             r_stat_ok;
  logic [7:0]       r_cnt_orphan;
  logic [7:0]       r_cnt_drop;

  logic             w_start;
  logic             w_cont;
  logic             w_orphan;
  logic             w_done;
  logic             w_ovf;
  logic             w_order;
  logic [LEN_W-1:0] w_len;
  logic [SW-1:0]    w_sum;
  logic [3:0]       w_code;

  // Packet state after the current beat; also the status of a completing packet.
  always_comb begin
    w_start  = bus.in_vld & bus.in_sop;
    w_cont   = bus.in_vld & ~bus.in_sop & (r_state == ACTIVE);
    w_orphan = bus.in_vld & ~bus.in_sop & (r_state == IDLE);
    w_done   = bus.in_eop & (w_start | w_cont);
    w_ovf    = 1'b0;
    w_order  = 1'b0;
    w_len    = r_len;
    w_sum    = r_sum;
    w_code   = r_code;
    if (w_start) begin
      w_len  = LEN_W'(1);
      w_sum  = SW'(bus.in_dat);
      w_code = {bus.in_err, 1'b0, (r_state == ACTIVE), 1'b0};
    end else if (w_cont) begin
      w_ovf   = (r_len == LEN_W'(N));
      w_order = (bus.in_dat < r_prev);
      w_len   = w_ovf ? r_len : r_len + LEN_W'(1);
      w_sum   = r_sum + SW'(bus.in_dat);
      w_code  = r_code | {bus.in_err, w_ovf, 1'b0, w_order};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_prev       <= '0;
      r_len        <= '0;
      r_sum        <= '0;
      r_code       <= '0;
      r_stat_vld   <= 1'b0;
      r_stat_len   <= '0;
      r_stat_sum   <= '0;
      r_stat_code  <= '0;
      r_stat_ok    <= 1'b0;
      r_cnt_orphan <= '0;
      r_cnt_drop   <= '0;
    end else begin
      if (w_start | w_cont) begin
        r_prev  <= bus.in_dat;
        r_len   <= w_len;
        r_sum   <= w_sum;
        r_code  <= w_code;
        r_state <= w_done ? IDLE : ACTIVE;
      end

      if (w_orphan && r_cnt_orphan != 8'hFF) begin
        r_cnt_orphan <= r_cnt_orphan + 8'd1;
      end

      // A held, unaccepted status wins over a newly completed one.
      if (w_done) begin
        if (!r_stat_vld || bus.stat_rdy) begin
          r_stat_vld  <= 1'b1;
          r_stat_len  <= w_len;
          r_stat_sum  <= w_sum;
          r_stat_code <= w_code;
          r_stat_ok   <= (w_code == 4'd0);
        end else if (r_cnt_drop != 8'hFF) begin
          r_cnt_drop <= r_cnt_drop + 8'd1;
        end
      end else if (r_stat_vld && bus.stat_rdy) begin
        r_stat_vld <= 1'b0;
      end
    end
  end

  assign bus.stat_vld_r   = r_stat_vld;
  assign bus.stat_len_r   = r_stat_len;
  assign bus.stat_sum_r   = r_stat_sum;
  assign bus.stat_code_r  = r_stat_code;
  assign bus.stat_ok_r    = r_stat_ok;
  assign bus.cnt_orphan_r = r_cnt_orphan;
  assign bus.cnt_drop_r   = r_cnt_drop;
endmodule

// File: tb/tb_qs_out_chk.sv
// Scoreboard bench for qs_out_chk: directed packets plus random traffic against a packet-level model.
module tb_qs_out_chk;
  localparam int unsigned W     = 32;
  localparam int unsigned N     = 16;
  localparam int unsigned LEN_W = $clog2(N) + 1;
  localparam int unsigned SW    = W + LEN_W;

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [SW-1:0]    sum;
    logic [3:0]       code;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qs_out_chk_if #(.W(W), .LEN_W(LEN_W)) bus ();
  qs_out_chk #(.W(W), .N(N), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  // Packet-level model
  bit           m_active = 1'b0;
  logic [W-1:0] m_beats[$];
  bit           m_frame = 1'b0;
  bit           m_err = 1'b0;
  bit           m_pend = 1'b0;
  int           m_orphan = 0;
  int           m_drop = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t calc();
    exp_t x;
    int   cnt;
    bit   order;
    cnt   = m_beats.size();
    order = 1'b0;
    x.sum = '0;
    for (int i = 0; i < cnt; i++) begin
      x.sum = x.sum + SW'(m_beats[i]);
      if (i > 0 && m_beats[i] < m_beats[i-1]) order = 1'b1;
    end
    x.len  = (cnt > int'(N)) ? LEN_W'(N) : LEN_W'(cnt);
    x.code = {m_err, (cnt > int'(N)), m_frame, order};
    return x;
  endfunction

  task automatic model_step(input bit v, input bit s, input bit e, input bit er,
                            input logic [W-1:0] d, input bit rdy);
    bit   done;
    exp_t x;
    done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_beats.delete();
      m_pend   = 1'b0;
      m_orphan = 0;
      m_drop   = 0;
      sb.delete();
      return;
    end
    if (v) begin
      if (s) begin
        m_frame = m_active;
        m_beats.delete();
        m_beats.push_back(d);
        m_err    = er;
        m_active = 1'b1;
      end else if (!m_active) begin
        if (m_orphan < 255) m_orphan++;
      end else begin
        m_beats.push_back(d);
        m_err = m_err | er;
      end
      if (e && m_active) begin
        x        = calc();
        done     = 1'b1;
        m_active = 1'b0;
      end
    end
    if (done) begin
      if (m_pend && !rdy) begin
        if (m_drop < 255) m_drop++;
      end else begin
        sb.push_back(x);
        m_pend = 1'b1;
      end
    end else if (m_pend && rdy) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic cyc(input bit v, input bit s, input bit e, input bit er,
                     input logic [W-1:0] d, input bit rdy);
    @(posedge clk);
    #1;
    bus.in_vld   = v;
    bus.in_sop   = s;
    bus.in_eop   = e;
    bus.in_err   = er;
    bus.in_dat   = d;
    bus.stat_rdy = rdy;
    model_step(v, s, e, er, d, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, rdy);
  endtask

  task automatic send_pkt(input logic [W-1:0] ds[$], input bit rdy, input int err_idx);
    for (int i = 0; i < ds.size(); i++)
      cyc(1'b1, i == 0, i == ds.size() - 1, i == err_idx, ds[i], rdy);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"},    64'(bus.stat_vld_r),   64'd0);
    chk({tag, "_len"},    64'(bus.stat_len_r),   64'd0);
    chk({tag, "_sum"},    64'(bus.stat_sum_r),   64'd0);
    chk({tag, "_code"},   64'(bus.stat_code_r),  64'd0);
    chk({tag, "_ok"},     64'(bus.stat_ok_r),    64'd0);
    chk({tag, "_orphan"}, 64'(bus.cnt_orphan_r), 64'd0);
    chk({tag, "_drop"},   64'(bus.cnt_drop_r),   64'd0);
  endtask

  task automatic do_reset();
    idle(3, 1'b1);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.in_vld = 1'b1;
    bus.in_sop = 1'b1;
    bus.in_eop = 1'b1;
    bus.in_dat = 32'd7;
    model_step(1'b1, 1'b1, 1'b1, 1'b0, 32'd7, 1'b1);
    @(posedge clk);
    #1;
    chk_zero("rst_a");
    bus.in_sop = 1'b0;
    @(posedge clk);
    #1;
    chk_zero("rst_b");
    rst        = 1'b0;
    bus.in_vld = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every accepted status and checks holding stability.
  bit               h_hold = 1'b0;
  logic [LEN_W-1:0] h_len;
  logic [SW-1:0]    h_sum;
  logic [3:0]       h_code;
  logic             h_ok;

  always @(negedge clk) begin
    exp_t x;
    if (rst) begin
      h_hold = 1'b0;
    end else begin
      if (h_hold) begin
        chk("hold_vld",  64'(bus.stat_vld_r),  64'd1);
        chk("hold_sum",  64'(bus.stat_sum_r),  64'(h_sum));
        chk("hold_len",  64'(bus.stat_len_r),  64'(h_len));
        chk("hold_code", 64'(bus.stat_code_r), 64'(h_code));
        chk("hold_ok",   64'(bus.stat_ok_r),   64'(h_ok));
      end
      if (bus.stat_vld_r && bus.stat_rdy) begin
        if (sb.size() == 0) begin
          chk("unexpected_status", 64'(bus.stat_vld_r), 64'd0);
        end else begin
          x = sb.pop_front();
          chk("stat_len",  64'(bus.stat_len_r),  64'(x.len));
          chk("stat_sum",  64'(bus.stat_sum_r),  64'(x.sum));
          chk("stat_code", 64'(bus.stat_code_r), 64'(x.code));
          chk("stat_ok",   64'(bus.stat_ok_r),   64'(x.code == 4'd0));
        end
      end
      h_hold = bus.stat_vld_r && !bus.stat_rdy;
      h_len  = bus.stat_len_r;
      h_sum  = bus.stat_sum_r;
      h_code = bus.stat_code_r;
      h_ok   = bus.stat_ok_r;
    end
  end

  initial begin
    logic [W-1:0] q[$];
    bus.in_vld   = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
    bus.in_err   = 1'b0;
    bus.in_dat   = '0;
    bus.stat_rdy = 1'b0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("init");
    rst = 1'b0;

    q = {32'd1, 32'd2, 32'd2, 32'd9};
    send_pkt(q, 1'b1, -1);
    idle(2, 1'b1);
    q = {32'd5, 32'd3, 32'd7};
    send_pkt(q, 1'b1, -1);
    idle(2, 1'b1);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd8, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd4, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd6, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 1'b1);
    idle(2, 1'b1);

    for (int i = 0; i < 20; i++) cyc(1'b1, i == 0, i == 19, 1'b0, 32'd1, 1'b1);
    idle(2, 1'b1);

    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd3, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'd4, 1'b0);
    idle(4, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'(10 + i), 1'b1);
    idle(3, 1'b1);
    chk("orphan_directed", 64'(bus.cnt_orphan_r), 64'd1);
    chk("drop_directed",   64'(bus.cnt_drop_r),   64'd1);

    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd10, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd11, 1'b1);
    do_reset();
    q = {32'd2, 32'd3, 32'd4};
    send_pkt(q, 1'b1, 1);
    idle(3, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] d;
      d = ($urandom % 4 == 0) ? W'($urandom) : W'($urandom_range(0, 20));
      cyc(($urandom % 10) < 7, ($urandom % 100) < 15, ($urandom % 100) < 15,
          ($urandom % 100) < 8, d, ($urandom % 10) < 6);
    end
    idle(6, 1'b1);

    chk("scoreboard_empty", 64'(sb.size()),        64'd0);
    chk("orphan_final",     64'(bus.cnt_orphan_r), 64'(m_orphan));
    chk("drop_final",       64'(bus.cnt_drop_r),   64'(m_drop));
    chk("vld_final",        64'(bus.stat_vld_r),   64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
